// File: rtl/board_win_scanner.sv
// Scans the 3x3 game-state memory into a shadow board through its read port,
// then evaluates the 8 winning lines and the full-board condition.
module board_win_scanner #(
    parameter int READ_LAT = 1,
    parameter int ADDR_W   = 4,
    parameter int PW       = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_req,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PW-1:0]     rd_data,
    output logic              busy,
    output logic              done,
    output logic              win,
    output logic [PW-1:0]     winner,
    output logic [2:0]        win_line,
    output logic              full
);

    typedef enum logic [2:0] {IDLE, READ, WAIT, EVAL, DONE} state_t;

    localparam int LINES [8][3] = '{
        '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
        '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
        '{0, 4, 8}, '{2, 4, 6}
    };

    state_t state, state_nxt;
    logic [3:0] cnt;

    logic [8:0][PW-1:0] shadow;
    logic               cap_vld;
    logic [ADDR_W-1:0]  cap_addr;

    logic               ev_win, ev_full;
    logic [PW-1:0]      ev_winner;
    logic [2:0]         ev_line;

    // Only codes 01 and 10 are players; 00 and the illegal 11 both count as empty.
    function automatic logic is_player(input logic [PW-1:0] c);
        return (c == PW'(1)) || (c == PW'(2));
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if ((state == READ || state == WAIT) && state_nxt == state)
                cnt <= cnt + 4'd1;
            else
                cnt <= '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (scan_req) state_nxt = READ;
            READ: if (cnt == 4'd8) state_nxt = (READ_LAT == 0) ? EVAL : WAIT;
            WAIT: if (cnt == 4'(READ_LAT - 1)) state_nxt = EVAL;
            EVAL: state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign rd_en   = (state == READ);
    assign rd_addr = rd_en ? ADDR_W'(cnt) : '0;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

    // Delay the issued address by the memory latency so each returning word
    // lands in the cell it was read from.
    generate
        if (READ_LAT == 0) begin : g_nolat
            assign cap_vld  = rd_en;
            assign cap_addr = rd_addr;
        end else begin : g_pipe
            logic [READ_LAT-1:0]             vld_pipe;
            logic [READ_LAT-1:0][ADDR_W-1:0] addr_pipe;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_pipe  <= '0;
                    addr_pipe <= '0;
                end else begin
                    vld_pipe[0]  <= rd_en;
                    addr_pipe[0] <= rd_addr;
                    for (int i = 1; i < READ_LAT; i++) begin
                        vld_pipe[i]  <= vld_pipe[i-1];
                        addr_pipe[i] <= addr_pipe[i-1];
                    end
                end
            end
            assign cap_vld  = vld_pipe[READ_LAT-1];
            assign cap_addr = addr_pipe[READ_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            shadow <= '0;
        else if (cap_vld && cap_addr < ADDR_W'(9))
            shadow[cap_addr] <= rd_data;
    end

    // Scan from the highest line down so the lowest winning index is the one kept.
    always_comb begin
        ev_win    = 1'b0;
        ev_winner = '0;
        ev_line   = '0;
        ev_full   = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            if (is_player(shadow[LINES[i][0]]) &&
                shadow[LINES[i][0]] == shadow[LINES[i][1]] &&
                shadow[LINES[i][1]] == shadow[LINES[i][2]]) begin
                ev_win    = 1'b1;
                ev_winner = shadow[LINES[i][0]];
                ev_line   = 3'(i);
            end
        end
        for (int k = 0; k < 9; k++)
            if (!is_player(shadow[k])) ev_full = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win      <= 1'b0;
            winner   <= '0;
            win_line <= '0;
            full     <= 1'b0;
        end else if (state == EVAL) begin
            win      <= ev_win;
            winner   <= ev_winner;
            win_line <= ev_line;
            full     <= ev_full;
        end
    end

endmodule

// File: tb/tb_board_win_scanner.sv
// Directed bench: three scanners (READ_LAT 0, 1, 2) share one board image, each
// behind its own memory latency model, and are checked against hand-computed results.
module tb_board_win_scanner;

    localparam logic [1:0] E = 2'b00, X = 2'b01, O = 2'b10, I = 2'b11;

    logic clk, rst, scan_req;
    logic [1:0] mem [0:15];

    logic       en0, en1, en2, bz0, bz1, bz2, dn0, dn1, dn2;
    logic       wn0, wn1, wn2, fl0, fl1, fl2;
    logic [3:0] ad0, ad1, ad2;
    logic [1:0] rd0, rd1, rd2, p2, wr0, wr1, wr2;
    logic [2:0] ln0, ln1, ln2;

    logic [6:0]  res_a [3];
    logic [13:0] all_a [3];
    logic        dn_a  [3];

    int total, fails;
    logic [6:0] prev_res;

    board_win_scanner #(.READ_LAT(0), .ADDR_W(4), .PW(2)) u0 (
        .clk(clk), .rst(rst), .scan_req(scan_req), .rd_en(en0), .rd_addr(ad0),
        .rd_data(rd0), .busy(bz0), .done(dn0), .win(wn0), .winner(wr0),
        .win_line(ln0), .full(fl0));
    board_win_scanner #(.READ_LAT(1), .ADDR_W(4), .PW(2)) u1 (
        .clk(clk), .rst(rst), .scan_req(scan_req), .rd_en(en1), .rd_addr(ad1),
        .rd_data(rd1), .busy(bz1), .done(dn1), .win(wn1), .winner(wr1),
        .win_line(ln1), .full(fl1));
    board_win_scanner #(.READ_LAT(2), .ADDR_W(4), .PW(2)) u2 (
        .clk(clk), .rst(rst), .scan_req(scan_req), .rd_en(en2), .rd_addr(ad2),
        .rd_data(rd2), .busy(bz2), .done(dn2), .win(wn2), .winner(wr2),
        .win_line(ln2), .full(fl2));

    always #5 clk = ~clk;

    // Memory models drive 11 outside read slots so stray captures would show up.
    assign rd0 = en0 ? mem[ad0] : I;
    always @(posedge clk) begin
        rd1 <= en1 ? mem[ad1] : I;
        p2  <= en2 ? mem[ad2] : I;
        rd2 <= p2;
    end

    always_comb begin
        res_a[0] = {wn0, wr0, ln0, fl0};
        res_a[1] = {wn1, wr1, ln1, fl1};
        res_a[2] = {wn2, wr2, ln2, fl2};
        all_a[0] = {en0, ad0, bz0, dn0, res_a[0]};
        all_a[1] = {en1, ad1, bz1, dn1, res_a[1]};
        all_a[2] = {en2, ad2, bz2, dn2, res_a[2]};
        dn_a[0]  = dn0;
        dn_a[1]  = dn1;
        dn_a[2]  = dn2;
    end

    task automatic load_board(input logic [0:8][1:0] b);
        for (int k = 0; k < 16; k++) mem[k] = (k < 9) ? b[k] : I;
    endtask

    task automatic run_scan(input string name, input logic [6:0] exp,
                            input int req_at, input int rst_at);
        int nd [3];
        int dat [3];
        for (int l = 0; l < 3; l++) begin nd[l] = 0; dat[l] = -1; end
        @(negedge clk); scan_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            scan_req = (i == req_at);
            if (i == rst_at) begin
                rst = 1'b1;
                #1;
                for (int l = 0; l < 3; l++) begin
                    total++;
                    if (all_a[l] !== '0) begin
                        fails++;
                        $display("FAIL %s abort_clear L=%0d got=%b exp=0", name, l, all_a[l]);
                    end
                end
                #1 rst = 1'b0;
                prev_res = '0;
            end
            if (rst_at < 0 || i < rst_at) begin
                total++;
                if ({en1, ad1} !== {(i <= 8), (i <= 8) ? 4'(i) : 4'd0}) begin
                    fails++;
                    $display("FAIL %s rd_seq i=%0d got en=%b addr=%0d", name, i, en1, ad1);
                end
                total++;
                if (bz1 !== (i <= 11)) begin
                    fails++;
                    $display("FAIL %s busy i=%0d got=%b exp=%b", name, i, bz1, (i <= 11));
                end
                if (i == 5) begin
                    total++;
                    if (res_a[1] !== prev_res) begin
                        fails++;
                        $display("FAIL %s hold got=%b exp=%b", name, res_a[1], prev_res);
                    end
                end
            end
            for (int l = 0; l < 3; l++)
                if (dn_a[l] === 1'b1) begin nd[l]++; dat[l] = i; end
        end
        scan_req = 1'b0;
        for (int l = 0; l < 3; l++) begin
            total++;
            if (nd[l] !== ((rst_at < 0) ? 1 : 0)) begin
                fails++;
                $display("FAIL %s done_count L=%0d got=%0d", name, l, nd[l]);
            end
            if (rst_at < 0) begin
                total++;
                if (dat[l] !== 10 + l) begin
                    fails++;
                    $display("FAIL %s done_cycle L=%0d got=%0d exp=%0d", name, l, dat[l], 10 + l);
                end
            end
            total++;
            if (res_a[l] !== exp) begin
                fails++;
                $display("FAIL %s result L=%0d got=%b exp=%b", name, l, res_a[l], exp);
            end
        end
        if (rst_at < 0) prev_res = exp;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        for (int l = 0; l < 3; l++) begin
            total++;
            if (all_a[l] !== '0) begin
                fails++;
                $display("FAIL reset L=%0d got=%b exp=0", l, all_a[l]);
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        total++;
        if (all_a[1] !== '0) begin
            fails++;
            $display("FAIL reset_idle got=%b exp=0", all_a[1]);
        end
        prev_res = '0;
    endtask

    task automatic test_empty();
        load_board({E, E, E, E, E, E, E, E, E});
        run_scan("empty", 7'b0_00_000_0, -1, -1);
    endtask

    task automatic test_diag();
        load_board({E, E, X, E, X, E, X, E, E});
        run_scan("diag", 7'b1_01_111_0, -1, -1);
    endtask

    task automatic test_draw();
        load_board({X, O, X, X, O, O, O, X, X});
        run_scan("draw", 7'b0_00_000_1, -1, -1);
        load_board({X, O, X, X, I, O, O, X, X});
        run_scan("draw_illegal", 7'b0_00_000_0, -1, -1);
    endtask

    task automatic test_priority();
        load_board({O, O, O, O, X, X, O, X, X});
        run_scan("row_col", 7'b1_10_000_1, -1, -1);
        load_board({E, O, E, E, O, E, X, X, X});
        run_scan("x_row2", 7'b1_01_010_0, -1, -1);
        load_board({O, O, O, E, E, E, X, X, X});
        run_scan("both_win", 7'b1_10_000_0, -1, -1);
    endtask

    task automatic test_ignore_req();
        load_board({E, E, X, E, X, E, X, E, E});
        run_scan("ignore_req", 7'b1_01_111_0, 3, -1);
    endtask

    task automatic test_abort();
        load_board({E, E, X, E, X, E, X, E, E});
        run_scan("abort", 7'b0_00_000_0, -1, 4);
    endtask

    task automatic test_back_to_back();
        int nd;
        int last;
        nd = 0; last = -1;
        load_board({X, X, X, E, O, O, E, E, E});
        @(negedge clk); scan_req = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            if (i == 12) begin
                total++;
                if (en1 !== 1'b0) begin
                    fails++;
                    $display("FAIL b2b idle_gap got en=%b exp=0", en1);
                end
            end
            if (i == 13) begin
                total++;
                if ({en1, ad1} !== 5'b1_0000) begin
                    fails++;
                    $display("FAIL b2b restart got en=%b addr=%0d exp en=1 addr=0", en1, ad1);
                end
                scan_req = 1'b0;
            end
            if (dn1 === 1'b1) begin nd++; last = i; end
        end
        total++;
        if (nd !== 2 || last !== 24) begin
            fails++;
            $display("FAIL b2b dones got=%0d last=%0d exp=2 last=24", nd, last);
        end
        total++;
        if (res_a[1] !== 7'b1_01_000_0) begin
            fails++;
            $display("FAIL b2b result got=%b exp=%b", res_a[1], 7'b1_01_000_0);
        end
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; scan_req = 1'b0;
        total = 0; fails = 0; prev_res = '0;
        load_board({E, E, E, E, E, E, E, E, E});
        test_reset();
        test_empty();
        test_diag();
        test_draw();
        test_priority();
        test_ignore_req();
        test_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", total, fails);
        $finish;
    end

endmodule
